ex_muldiv_unit: RTL and testbench
=================================

EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-high reset.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have port: start  input  1  M-extension op present in EX this cycle.
REQ-005 SHALL have port: aluop  input  5  operation: 01000 MUL, 01001 MULH, 01010 MULHSU, 01011 MULHU, 01100 DIV, 01101 DIVU, 01110 REM, 01111 REMU.
REQ-006 SHALL have port: operand_a  input  32  rs1 value (multiplicand/dividend).
REQ-007 SHALL have port: operand_b  input  32  rs2 value (multiplier/divisor).
REQ-008 SHALL have port: stall_in  input  1  downstream busywait; result must be held.
REQ-009 SHALL have port: flush  input  1  synchronous abort (branch/jump redirect).
REQ-010 SHALL have port: busy  output  1  stall request to ID/EX and earlier stages.
REQ-011 SHALL have port: result  output  32  final value.
REQ-012 SHALL have port: result_valid  output  1  result is valid this cycle.

Function
REQ-013 SHALL implement the FSM states IDLE, CALC and DONE.
REQ-014 In IDLE with start=1, a valid aluop and flush=0, the block SHALL, on the clock edge: latch aluop; latch the operand magnitudes and result-sign flags per signedness (MULH/DIV/REM both signed, MULHSU signed a only, others unsigned); clear the 6-bit counter; and move to CALC.
REQ-015 In IDLE, start with an aluop outside 01000-01111 SHALL be ignored.
REQ-016 In CALC, the block SHALL perform exactly one radix-2 iteration per cycle (shift-add for multiply, restoring shift-subtract for divide) for 32 cycles, then move to DONE.
REQ-017 Multiply SHALL form a 64-bit product: MUL returns bits[31:0]; MULH, MULHSU and MULHU return bits[63:32] after sign correction.
REQ-018 Division SHALL truncate toward zero, and the remainder sign SHALL equal the dividend sign.
REQ-019 Divide by zero SHALL give: DIV/DIVU = 0xFFFFFFFF; REM/REMU = operand_a.
REQ-020 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL give: DIV = 0x80000000; REM = 0.
REQ-021 Special cases SHALL keep the full fixed latency, with no early exit.
REQ-022 busy SHALL be combinational and equal (IDLE & start & valid aluop & !flush) | CALC; in DONE, busy SHALL be 0.
REQ-023 Latency: with the start cycle as cycle 1, busy SHALL be high for cycles 1-33, and result/result_valid SHALL be valid in cycle 34.
REQ-024 In DONE, result_valid SHALL be 1, and the state SHALL remain DONE while stall_in=1, with result held stable.
REQ-025 In DONE with stall_in=0, the state SHALL go to IDLE, and start asserted in that DONE cycle SHALL NOT relaunch an operation.
REQ-026 flush=1 in any state SHALL force IDLE at the next edge and clear result_valid; flush SHALL take priority over start and stall_in.
REQ-027 result SHALL hold its last value in IDLE, and result_valid SHALL be 0 outside DONE.
REQ-028 Operand changes after the launch edge SHALL NOT affect the result.

Reset
REQ-029 rst=1 SHALL force, immediately and asynchronously: state IDLE, counter 0, result 0, result_valid 0, and all internal accumulators and latched operands 0.
REQ-030 rst=1 mid-CALC or mid-DONE SHALL discard the operation; after release, busy SHALL be 0 until a new start.

Verification
REQ-031 The bench SHALL cover MUL 7 x 0xFFFFFFFD, which SHALL give result 0xFFFFFFEB in cycle 34 and busy high in cycles 1-33.
REQ-032 The bench SHALL cover MULH 0x80000000 x 0x80000000, which SHALL give 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF, which SHALL give 0xFFFFFFFE; and MULHSU 0xFFFFFFFF x 0xFFFFFFFF, which SHALL give 0xFFFFFFFF.
REQ-033 The bench SHALL cover DIV 0xFFFFFFF9 / 2, which SHALL give 0xFFFFFFFD, and REM with the same operands, which SHALL give 0xFFFFFFFF.
REQ-034 The bench SHALL cover DIVU 5/0, which SHALL give 0xFFFFFFFF; REMU 5/0, which SHALL give 5; DIV 0x80000000 / 0xFFFFFFFF, which SHALL give 0x80000000; and REM with the same operands, which SHALL give 0.
REQ-035 The bench SHALL cover start held during DONE with stall_in=1 for 3 cycles, which SHALL keep result stable and result_valid high for 4 cycles and then return to IDLE without relaunch.
REQ-036 The bench SHALL cover flush at CALC cycle 10, which SHALL give IDLE at the next edge and busy=0; and rst at CALC cycle 20, which SHALL immediately give result=0 and result_valid=0.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: radix-2 shift-add multiply,
// restoring divide, fixed 32-iteration latency, result held in DONE while stalled.
module ex_muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [4:0]  aluop,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic        stall_in,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] result,
    output logic        result_valid
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state_q;
    logic [2:0]  op_q;
    logic [31:0] opnd_q;
    logic [63:0] acc_q;
    logic        neg_q;
    logic        div_zero_q;
    logic [5:0]  cnt_q;
    logic [31:0] result_q;
    logic        valid_q;

    logic        op_valid;
    logic        launch;
    logic        sign_a;
    logic        sign_b;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] launch_opnd;
    logic [63:0] launch_acc;
    logic        launch_neg;

    logic [32:0] mul_sum;
    logic [32:0] rem_shift;
    logic        rem_ge;
    logic [31:0] rem_sub;
    logic [63:0] acc_d;
    logic [63:0] prod;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [31:0] result_d;

    assign op_valid     = (aluop[4:3] == 2'b01);
    assign launch       = (state_q == IDLE) && start && op_valid && !flush;
    assign busy         = launch || (state_q == CALC);
    assign result       = result_q;
    assign result_valid = valid_q;

    // Operands are reduced to unsigned magnitudes at launch; the sign is reapplied at the end.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        sign_a = 1'b0;
        sign_b = 1'b0;
        case (aluop[2:0])
            3'b001, 3'b100, 3'b110: begin sign_a = 1'b1; sign_b = 1'b1; end
            3'b010:                 sign_a = 1'b1;
            default: ;
        endcase
        a_neg = sign_a && operand_a[31];
        b_neg = sign_b && operand_b[31];
        a_mag = a_neg ? -operand_a : operand_a;
        b_mag = b_neg ? -operand_b : operand_b;
        if (aluop[2]) begin
            launch_opnd = b_mag;
            launch_acc  = {32'd0, a_mag};
            launch_neg  = aluop[1] ? a_neg : (a_neg ^ b_neg);
        end else begin
            launch_opnd = a_mag;
            launch_acc  = {32'd0, b_mag};
            launch_neg  = a_neg ^ b_neg;
        end
    end

    // One iteration: acc holds {partial product, multiplier} or {remainder, quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
        rem_shift = {acc_q[63:32], acc_q[31]};
        rem_ge    = (rem_shift >= {1'b0, opnd_q});
        rem_sub   = rem_shift[31:0] - opnd_q;
        if (op_q[2])
            acc_d = rem_ge ? {rem_sub, acc_q[30:0], 1'b1}
                           : {rem_shift[31:0], acc_q[30:0], 1'b0};
        else
            acc_d = {mul_sum, acc_q[31:1]};
    end

    always_comb begin
        prod = neg_q ? -acc_d : acc_d;
        quot = acc_d[31:0];
        rem  = acc_d[63:32];
        if (!op_q[2])
            result_d = (op_q[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
        else if (!op_q[1])
            result_d = div_zero_q ? 32'hFFFF_FFFF : (neg_q ? -quot : quot);
        else
            result_d = neg_q ? -rem : rem;
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= 3'd0;
            opnd_q     <= 32'd0;
            acc_q      <= 64'd0;
            neg_q      <= 1'b0;
            div_zero_q <= 1'b0;
            cnt_q      <= 6'd0;
            result_q   <= 32'd0;
            valid_q    <= 1'b0;
        end else if (flush) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (launch) begin
                        op_q       <= aluop[2:0];
                        opnd_q     <= launch_opnd;
                        acc_q      <= launch_acc;
                        neg_q      <= launch_neg;
                        div_zero_q <= (operand_b == 32'd0);
                        cnt_q      <= 6'd0;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        result_q <= result_d;
                        valid_q  <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    // start is ignored here; a new op needs a fresh IDLE cycle.
                    if (!stall_in) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: table of directed vectors plus hand-written
// sequences for stall hold, flush, idle-cycle corner cases and mid-operation reset.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  aluop;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        stall_in;
    logic        flush;
    logic        busy;
    logic [31:0] result;
    logic        result_valid;

    int n_pass  = 0;
    int n_total = 0;

    localparam logic [4:0] OP_MUL    = 5'b01000;
    localparam logic [4:0] OP_MULH   = 5'b01001;
    localparam logic [4:0] OP_MULHSU = 5'b01010;
    localparam logic [4:0] OP_MULHU  = 5'b01011;
    localparam logic [4:0] OP_DIV    = 5'b01100;
    localparam logic [4:0] OP_DIVU   = 5'b01101;
    localparam logic [4:0] OP_REM    = 5'b01110;
    localparam logic [4:0] OP_REMU   = 5'b01111;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[18];

    ex_muldiv_unit dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .aluop       (aluop),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .stall_in    (stall_in),
        .flush       (flush),
        .busy        (busy),
        .result      (result),
        .result_valid(result_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Drives start in cycle 1 (sampled 1 time unit after the falling edge).
    task automatic launch_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        aluop     = op;
        operand_a = a;
        operand_b = b;
        start     = 1'b1;
        #1;
    endtask

    // Moves to the next cycle; in cycle 2 drops start and scrambles the operand inputs.
    task automatic next_cycle(input int cyc, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        if (cyc == 2) begin
            start     = 1'b0;
            operand_a = ~a ^ 32'h5A5A_0F0F;
            operand_b = b + 32'd3;
            aluop     = 5'b01010;
        end
        #1;
    endtask

    // Runs one operation and returns in cycle 34 with the result checked.
    task automatic run_vec(input string name, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        int nb;
        int nv;
        nb = 0;
        nv = 0;
        launch_op(op, a, b);
        for (int cyc = 1; cyc <= 33; cyc++) begin
            if (cyc > 1) next_cycle(cyc, a, b);
            if (busy) nb++;
            if (result_valid) nv++;
        end
        next_cycle(34, a, b);
        check({name, "_busy_cycles"}, nb, 33);
        check({name, "_early_valid"}, nv, 0);
        check({name, "_busy_done"}, {31'd0, busy}, 32'd0);
        check({name, "_valid"}, {31'd0, result_valid}, 32'd1);
        check({name, "_result"}, result, exp);
    endtask

    initial begin
        vecs[0]  = '{OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1]  = '{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vecs[2]  = '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[3]  = '{OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[4]  = '{OP_DIV,    32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD};
        vecs[5]  = '{OP_REM,    32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF};
        vecs[6]  = '{OP_DIVU,   32'd5,          32'd0,          32'hFFFF_FFFF};
        vecs[7]  = '{OP_REMU,   32'd5,          32'd0,          32'd5};
        vecs[8]  = '{OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[9]  = '{OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
        vecs[10] = '{OP_MUL,    32'h1234_5678, 32'h10,         32'h2345_6780};
        vecs[11] = '{OP_MULHU,  32'h1234_5678, 32'h10,         32'd1};
        vecs[12] = '{OP_MULH,   32'hFFFF_FFFF, 32'd5,          32'hFFFF_FFFF};
        vecs[13] = '{OP_DIVU,   32'd100,        32'd7,          32'd14};
        vecs[14] = '{OP_REMU,   32'd100,        32'd7,          32'd2};
        vecs[15] = '{OP_DIV,    32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2};
        vecs[16] = '{OP_REM,    32'd100,        32'hFFFF_FFF9, 32'd2};
        vecs[17] = '{OP_REM,    32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFF9};

        rst       = 1'b1;
        start     = 1'b0;
        aluop     = 5'd0;
        operand_a = 32'd0;
        operand_b = 32'd0;
        stall_in  = 1'b0;
        flush     = 1'b0;
        #1;
        check("reset_result", result, 32'd0);
        check("reset_valid", {31'd0, result_valid}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
            next_cycle(35, 32'd0, 32'd0);
            check($sformatf("vec%0d_idle_valid", i), {31'd0, result_valid}, 32'd0);
        end

        // DONE held by stall_in for 3 cycles while start is asserted.
        run_vec("stall", OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        stall_in = 1'b1;
        start    = 1'b1;
        aluop    = OP_DIVU;
        for (int k = 35; k <= 37; k++) begin
            next_cycle(k, 32'd0, 32'd0);
            check($sformatf("stall_c%0d_valid", k), {31'd0, result_valid}, 32'd1);
            check($sformatf("stall_c%0d_result", k), result, 32'hFFFF_FFEB);
            check($sformatf("stall_c%0d_busy", k), {31'd0, busy}, 32'd0);
        end
        stall_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("stall_release_valid", {31'd0, result_valid}, 32'd0);
        check("stall_release_busy", {31'd0, busy}, 32'd0);
        next_cycle(0, 32'd0, 32'd0);
        check("stall_no_relaunch", {31'd0, busy}, 32'd0);
        check("stall_idle_hold", result, 32'hFFFF_FFEB);

        // Flush in CALC cycle 10 (overall cycle 11).
        launch_op(OP_DIVU, 32'd100, 32'd7);
        for (int cyc = 2; cyc <= 11; cyc++) next_cycle(cyc, 32'd100, 32'd7);
        check("flush_busy_before", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_busy_after", {31'd0, busy}, 32'd0);
        check("flush_valid_after", {31'd0, result_valid}, 32'd0);
        check("flush_result_held", result, 32'hFFFF_FFEB);
        begin
            int nv;
            nv = 0;
            for (int k = 0; k < 30; k++) begin
                next_cycle(0, 32'd0, 32'd0);
                if (busy || result_valid) nv++;
            end
            check("flush_stays_idle", nv, 0);
        end

        // flush beats start in IDLE; an invalid aluop is ignored.
        launch_op(OP_MUL, 32'd3, 32'd4);
        flush = 1'b1;
        #1;
        check("idle_flush_busy", {31'd0, busy}, 32'd0);
        next_cycle(2, 32'd3, 32'd4);
        flush = 1'b0;
        #1;
        check("idle_flush_no_launch", {31'd0, busy}, 32'd0);
        launch_op(5'b10000, 32'd3, 32'd4);
        check("bad_op_busy", {31'd0, busy}, 32'd0);
        next_cycle(2, 32'd3, 32'd4);
        check("bad_op_no_launch", {31'd0, busy}, 32'd0);

        // Asynchronous reset at CALC cycle 20 (overall cycle 21).
        launch_op(OP_MUL, 32'h1234_5678, 32'h10);
        for (int cyc = 2; cyc <= 21; cyc++) next_cycle(cyc, 32'h1234_5678, 32'h10);
        rst = 1'b1;
        #1;
        check("rst_result", result, 32'd0);
        check("rst_valid", {31'd0, result_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        begin
            int nv;
            nv = 0;
            for (int k = 0; k < 40; k++) begin
                next_cycle(0, 32'd0, 32'd0);
                if (busy || result_valid) nv++;
            end
            check("rst_stays_idle", nv, 0);
        end

        run_vec("after_rst", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
